// File: rtl/replace_victim_ctrl.sv
// Two-way FIFO victim selector driving a 128-entry replacement-pointer bit buffer.
// Optional read forwarding of the last written pointer bit: define REPLACE_VICTIM_FWD_EN.
module replace_victim_ctrl (
  input  logic       fire,
  input  logic       rstn,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [6:0] i_set_addr_7,
  input  logic       i_hit,
  input  logic [1:0] i_way_valid,
  output logic [6:0] o_buf_addr_7,
  output logic       o_buf_write_enable,
  output logic       o_buf_data_in,
  input  logic       i_buf_data_out,
  output logic       o_victim_valid,
  output logic       o_victim_way,
  input  logic       i_victim_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    UPD  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] way_valid_q;
  logic       accept;
  logic       ptr_bit;
  logic       victim;
  logic       fwd_hit;

  assign accept = i_req_valid & (state == IDLE);

`ifdef REPLACE_VICTIM_FWD_EN
  logic [6:0] last_addr;
  logic       last_bit;
  logic       last_vld;
  logic       fwd_sel;

  assign fwd_hit = last_vld & (i_set_addr_7 == last_addr);
  assign ptr_bit = fwd_sel ? last_bit : i_buf_data_out;

  always_ff @(posedge fire or negedge rstn) begin
    if (!rstn) begin
      last_addr <= '0;
      last_bit  <= 1'b0;
      last_vld  <= 1'b0;
      fwd_sel   <= 1'b0;
    end else begin
      if (accept)
        fwd_sel <= fwd_hit;
      // Track the bit just written so a repeat miss can bypass the buffer read
      if (state == UPD) begin
        last_addr <= o_buf_addr_7;
        last_bit  <= ~victim;
        last_vld  <= 1'b1;
      end
    end
  end
`else
  assign fwd_hit = 1'b0;
  assign ptr_bit = i_buf_data_out;
`endif

  // An invalid way always wins; way_valid_q[0] is 0 exactly when way0 is free
  assign victim = (way_valid_q != 2'b11) ? way_valid_q[0] : ptr_bit;

  always_ff @(posedge fire or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      o_buf_addr_7 <= '0;
      way_valid_q  <= '0;
      o_victim_way <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        o_buf_addr_7 <= i_set_addr_7;
        way_valid_q  <= i_way_valid;
      end
      if (state == UPD)
        o_victim_way <= victim;
    end
  end

  always_comb begin
    state_nxt          = state;
    o_req_ready        = 1'b0;
    o_buf_write_enable = 1'b0;
    o_buf_data_in      = 1'b0;
    o_victim_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid && !i_hit)
          state_nxt = fwd_hit ? UPD : RD;
      end
      RD:   state_nxt = UPD;
      UPD: begin
        o_buf_write_enable = 1'b1;
        o_buf_data_in      = ~victim;
        state_nxt          = RESP;
      end
      RESP: begin
        o_victim_valid = 1'b1;
        if (i_victim_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_replace_victim_ctrl.sv
// Directed bench for replace_victim_ctrl with a behavioural registered-read pointer buffer.
module tb_replace_victim_ctrl;

  logic       fire = 1'b0;
  logic       rstn;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [6:0] i_set_addr_7;
  logic       i_hit;
  logic [1:0] i_way_valid;
  logic [6:0] o_buf_addr_7;
  logic       o_buf_write_enable;
  logic       o_buf_data_in;
  logic       i_buf_data_out;
  logic       o_victim_valid;
  logic       o_victim_way;
  logic       i_victim_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic       mem [128];
  logic [6:0] m_last_addr;
  logic       m_last_vld;

  always #5 fire = ~fire;

  replace_victim_ctrl dut (
    .fire               (fire),
    .rstn               (rstn),
    .i_req_valid        (i_req_valid),
    .o_req_ready        (o_req_ready),
    .i_set_addr_7       (i_set_addr_7),
    .i_hit              (i_hit),
    .i_way_valid        (i_way_valid),
    .o_buf_addr_7       (o_buf_addr_7),
    .o_buf_write_enable (o_buf_write_enable),
    .o_buf_data_in      (o_buf_data_in),
    .i_buf_data_out     (i_buf_data_out),
    .o_victim_valid     (o_victim_valid),
    .o_victim_way       (o_victim_way),
    .i_victim_ready     (i_victim_ready)
  );

  // Replacement bit buffer: write-then-registered-read on the same clock
  always @(posedge fire) begin
    if (o_buf_write_enable)
      mem[o_buf_addr_7] <= o_buf_data_in;
    i_buf_data_out <= mem[o_buf_addr_7];
  end

  task automatic tick();
    @(posedge fire);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic miss_to_resp(input logic [6:0] addr, input logic [1:0] wv, input logic exp_way);
    logic exp_rd;
    exp_rd = 1'b1;
`ifdef REPLACE_VICTIM_FWD_EN
    if (m_last_vld && (m_last_addr == addr))
      exp_rd = 1'b0;
`endif
    chk("idle_ready", {31'd0, o_req_ready}, 32'd1);
    i_req_valid    = 1'b1;
    i_hit          = 1'b0;
    i_set_addr_7   = addr;
    i_way_valid    = wv;
    i_victim_ready = 1'b0;
    tick();
    // Request stays asserted with a different address: must be ignored
    i_set_addr_7   = ~addr;
    if (exp_rd) begin
      i_victim_ready = 1'b1;
      chk("rd_ready", {31'd0, o_req_ready}, 32'd0);
      chk("rd_we", {31'd0, o_buf_write_enable}, 32'd0);
      chk("rd_addr", {25'd0, o_buf_addr_7}, {25'd0, addr});
      chk("rd_vvalid", {31'd0, o_victim_valid}, 32'd0);
      tick();
    end
    i_victim_ready = 1'b0;
    chk("upd_we", {31'd0, o_buf_write_enable}, 32'd1);
    chk("upd_din", {31'd0, o_buf_data_in}, {31'd0, ~exp_way});
    chk("upd_addr", {25'd0, o_buf_addr_7}, {25'd0, addr});
    chk("upd_vvalid", {31'd0, o_victim_valid}, 32'd0);
    i_req_valid = 1'b0;
    tick();
    m_last_addr = addr;
    m_last_vld  = 1'b1;
    chk("resp_vvalid", {31'd0, o_victim_valid}, 32'd1);
    chk("resp_way", {31'd0, o_victim_way}, {31'd0, exp_way});
    chk("resp_we", {31'd0, o_buf_write_enable}, 32'd0);
    chk("resp_ready", {31'd0, o_req_ready}, 32'd0);
  endtask

  task automatic finish_resp();
    i_victim_ready = 1'b1;
    tick();
    i_victim_ready = 1'b0;
    chk("ret_ready", {31'd0, o_req_ready}, 32'd1);
    chk("ret_vvalid", {31'd0, o_victim_valid}, 32'd0);
  endtask

  task automatic miss(input logic [6:0] addr, input logic [1:0] wv, input logic exp_way);
    miss_to_resp(addr, wv, exp_way);
    finish_resp();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 1'b0;
    m_last_addr    = '0;
    m_last_vld     = 1'b0;
    rstn           = 1'b0;
    i_req_valid    = 1'b0;
    i_set_addr_7   = '0;
    i_hit          = 1'b0;
    i_way_valid    = '0;
    i_victim_ready = 1'b0;
    #1;
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_we", {31'd0, o_buf_write_enable}, 32'd0);
    chk("rst_din", {31'd0, o_buf_data_in}, 32'd0);
    chk("rst_addr", {25'd0, o_buf_addr_7}, 32'd0);
    chk("rst_vvalid", {31'd0, o_victim_valid}, 32'd0);
    chk("rst_way", {31'd0, o_victim_way}, 32'd0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // FIFO pointer alternates on a fully valid set
    miss(7'd5, 2'b11, 1'b0);
    miss(7'd5, 2'b11, 1'b1);
    miss(7'd5, 2'b11, 1'b0);

    // Invalid way overrides the pointer
    miss(7'd9, 2'b10, 1'b0);
    miss(7'd9, 2'b01, 1'b1);

    // Hit: no buffer access, stays idle
    i_req_valid  = 1'b1;
    i_hit        = 1'b1;
    i_set_addr_7 = 7'd3;
    i_way_valid  = 2'b11;
    tick();
    chk("hit_ready", {31'd0, o_req_ready}, 32'd1);
    chk("hit_we", {31'd0, o_buf_write_enable}, 32'd0);
    chk("hit_vvalid", {31'd0, o_victim_valid}, 32'd0);
    chk("hit_addr", {25'd0, o_buf_addr_7}, 32'd3);
    i_req_valid = 1'b0;
    i_hit       = 1'b0;
    tick();
    chk("hit2_we", {31'd0, o_buf_write_enable}, 32'd0);
    chk("hit2_vvalid", {31'd0, o_victim_valid}, 32'd0);
    miss(7'd3, 2'b11, 1'b0);

    // Consumer stalls for 5 cycles
    miss_to_resp(7'd20, 2'b11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_vvalid", {31'd0, o_victim_valid}, 32'd1);
      chk("hold_way", {31'd0, o_victim_way}, 32'd0);
      chk("hold_we", {31'd0, o_buf_write_enable}, 32'd0);
    end
    finish_resp();

    // Asynchronous reset in RESP aborts the transaction
    miss_to_resp(7'd21, 2'b11, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_vvalid", {31'd0, o_victim_valid}, 32'd0);
    chk("arst_way", {31'd0, o_victim_way}, 32'd0);
    chk("arst_we", {31'd0, o_buf_write_enable}, 32'd0);
    chk("arst_din", {31'd0, o_buf_data_in}, 32'd0);
    chk("arst_addr", {25'd0, o_buf_addr_7}, 32'd0);
    chk("arst_ready", {31'd0, o_req_ready}, 32'd1);
    #1;
    rstn       = 1'b1;
    m_last_vld = 1'b0;
    tick();
    chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
    // Set 21 pointer was already written to 1 before the reset
    miss(7'd21, 2'b11, 1'b1);

    // Repeat misses on 127 (forwarded when enabled), broken by set 0
    miss(7'd127, 2'b11, 1'b0);
    miss(7'd127, 2'b11, 1'b1);
    miss(7'd0, 2'b11, 1'b0);
    miss(7'd127, 2'b11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
